// File: rtl/add_n_sat.sv
// add_n_sat: N-input streaming adder with scaling and saturate/wrap.
// Reads FWFT input FIFOs, writes one holding stage ahead of the output FIFO.
module add_n_sat #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 4,
    parameter int SHIFT      = 0,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] din,
    input  logic [NUM_INPUTS-1:0]          in_empty,
    output logic [NUM_INPUTS-1:0]          in_rd_en,
    input  logic [NUM_INPUTS-1:0]          ch_mask,
    input  logic                           sat_en,
    input  logic                           sat_clr,
    input  logic                           out_full,
    output logic [DATA_WIDTH-1:0]          dout,
    output logic                           out_wr_en,
    output logic                           frame_done,
    output logic                           sat_flag
);

    localparam int GW = $clog2(NUM_INPUTS);
    localparam int SW = DATA_WIDTH + GW;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    localparam logic signed [SW-1:0] MAX_V =
        {{(GW + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V =
        {{(GW + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [CW-1:0]         frame_cnt;

    logic signed [SW-1:0]  sum;
    logic signed [SW-1:0]  res;
    logic                  over;
    logic                  under;
    logic                  out_of_range;
    logic [DATA_WIDTH-1:0] result;

    logic all_avail;
    logic any_en;
    logic space;
    logic accept;

    // Masked channels contribute zero; sign-extend each lane to SW bits.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (ch_mask[k]) begin
                sum = sum + {{GW{din[k*DATA_WIDTH + DATA_WIDTH - 1]}},
                             din[k*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    assign res          = sum >>> SHIFT;
    assign over         = res > MAX_V;
    assign under        = res < MIN_V;
    assign out_of_range = over | under;

    always_comb begin
        result = res[DATA_WIDTH-1:0];
        if (sat_en && over) begin
            result = MAX_V[DATA_WIDTH-1:0];
        end else if (sat_en && under) begin
            result = MIN_V[DATA_WIDTH-1:0];
        end
    end

    assign all_avail = &(~ch_mask | ~in_empty);
    assign any_en    = |ch_mask;
    assign space     = ~hold_valid | ~out_full;
    // Reset also gates the pop so no FIFO is drained while held in reset.
    assign accept    = ~reset & all_avail & any_en & space;

    assign in_rd_en   = accept ? ch_mask : '0;
    assign out_wr_en  = hold_valid & ~out_full;
    assign dout       = hold_data;
    assign frame_done = out_wr_en & (frame_cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= result;
        end else if (out_wr_en) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (accept && out_of_range) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (out_wr_en) begin
            if (frame_cnt == LAST) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_add_n_sat.sv
// Directed bench for add_n_sat: SHIFT=0 and SHIFT=2 instances,
// 4 channels of 8 bits, FRAME_LEN=4.
module tb_add_n_sat;

    logic        clock;
    logic        reset;

    logic [31:0] din;
    logic [3:0]  in_empty;
    logic [3:0]  in_rd_en;
    logic [3:0]  ch_mask;
    logic        sat_en;
    logic        sat_clr;
    logic        out_full;
    logic [7:0]  dout;
    logic        out_wr_en;
    logic        frame_done;
    logic        sat_flag;

    logic [31:0] s_din;
    logic [3:0]  s_empty;
    logic [3:0]  s_rd_en;
    logic [3:0]  s_mask;
    logic        s_sat_en;
    logic        s_sat_clr;
    logic        s_full;
    logic [7:0]  s_dout;
    logic        s_wr_en;
    logic        s_frame_done;
    logic        s_sat_flag;

    int tests;
    int fails;

    add_n_sat #(
        .DATA_WIDTH(8), .NUM_INPUTS(4), .SHIFT(0), .FRAME_LEN(4)
    ) u_dut (
        .clock(clock), .reset(reset), .din(din), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .ch_mask(ch_mask), .sat_en(sat_en),
        .sat_clr(sat_clr), .out_full(out_full), .dout(dout),
        .out_wr_en(out_wr_en), .frame_done(frame_done),
        .sat_flag(sat_flag)
    );

    add_n_sat #(
        .DATA_WIDTH(8), .NUM_INPUTS(4), .SHIFT(2), .FRAME_LEN(4)
    ) u_dut_s2 (
        .clock(clock), .reset(reset), .din(s_din), .in_empty(s_empty),
        .in_rd_en(s_rd_en), .ch_mask(s_mask), .sat_en(s_sat_en),
        .sat_clr(s_sat_clr), .out_full(s_full), .dout(s_dout),
        .out_wr_en(s_wr_en), .frame_done(s_frame_done),
        .sat_flag(s_sat_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_din(input int a, input int b, input int c,
                           input int d);
        din = {8'(d), 8'(c), 8'(b), 8'(a)};
    endtask

    initial begin
        int next_in;
        int exp_out;
        int n_out;
        logic popped;

        tests = 0;
        fails = 0;

        reset     = 1'b1;
        in_empty  = 4'b0000;
        ch_mask   = 4'b1111;
        sat_en    = 1'b1;
        sat_clr   = 1'b0;
        out_full  = 1'b0;
        set_din(10, 20, -5, 3);
        s_din     = '0;
        s_empty   = 4'b1111;
        s_mask    = 4'b0000;
        s_sat_en  = 1'b1;
        s_sat_clr = 1'b0;
        s_full    = 1'b0;
        #1;
        chk("rst_rd_en", 32'(in_rd_en), 32'(4'b0000));
        chk("rst_wr_en", 32'(out_wr_en), 32'(1'b0));
        chk("rst_dout", 32'(dout), 32'(8'd0));
        chk("rst_frame", 32'(frame_done), 32'(1'b0));
        chk("rst_sat", 32'(sat_flag), 32'(1'b0));

        // basic sum 10+20-5+3
        tick();
        reset = 1'b0;
        #1;
        chk("basic_rd0", 32'(in_rd_en), 32'(4'b1111));
        chk("basic_wr0", 32'(out_wr_en), 32'(1'b0));
        tick();
        #1;
        chk("basic_wr1", 32'(out_wr_en), 32'(1'b1));
        chk("basic_dout1", 32'(dout), 32'(8'd28));
        chk("basic_rd1", 32'(in_rd_en), 32'(4'b1111));
        tick();
        #1;
        chk("basic_wr2", 32'(out_wr_en), 32'(1'b1));
        chk("basic_dout2", 32'(dout), 32'(8'd28));

        // saturate, wrap, negative saturate
        set_din(100, 100, 50, 0);
        sat_en = 1'b1;
        tick();
        #1;
        chk("sat_pos", 32'(dout), 32'(8'd127));
        chk("sat_flag_set", 32'(sat_flag), 32'(1'b1));
        sat_en = 1'b0;
        tick();
        #1;
        chk("wrap_pos", 32'(dout), 32'(8'hFA));
        chk("wrap_flag", 32'(sat_flag), 32'(1'b1));
        set_din(-100, -100, -100, -100);
        sat_en = 1'b1;
        tick();
        #1;
        chk("sat_neg", 32'(dout), 32'(8'h80));
        set_din(1, 2, 3, 4);
        sat_clr = 1'b1;
        tick();
        #1;
        chk("clr_dout", 32'(dout), 32'(8'd10));
        chk("clr_flag", 32'(sat_flag), 32'(1'b0));
        set_din(100, 100, 50, 0);
        tick();
        #1;
        chk("set_wins", 32'(sat_flag), 32'(1'b1));
        chk("set_wins_dout", 32'(dout), 32'(8'd127));

        // mask and empty
        sat_clr  = 1'b0;
        ch_mask  = 4'b0101;
        in_empty = 4'b1010;
        set_din(10, 20, 30, 40);
        #1;
        chk("mask_rd", 32'(in_rd_en), 32'(4'b0101));
        tick();
        #1;
        chk("mask_dout", 32'(dout), 32'(8'd40));
        chk("mask_wr", 32'(out_wr_en), 32'(1'b1));
        in_empty = 4'b1110;
        #1;
        chk("empty_rd", 32'(in_rd_en), 32'(4'b0000));
        tick();
        #1;
        chk("empty_wr", 32'(out_wr_en), 32'(1'b0));
        ch_mask  = 4'b0000;
        in_empty = 4'b0000;
        #1;
        chk("idle_rd0", 32'(in_rd_en), 32'(4'b0000));
        tick();
        #1;
        chk("idle_rd1", 32'(in_rd_en), 32'(4'b0000));
        chk("idle_wr", 32'(out_wr_en), 32'(1'b0));

        // backpressure: ch0 carries a counting sequence
        ch_mask = 4'b0001;
        next_in = 1;
        exp_out = 1;
        n_out   = 0;
        for (int i = 0; i < 60 && n_out < 20; i++) begin
            out_full = (i >= 5 && i < 10);
            din = {24'd0, 8'(next_in)};
            #1;
            if (out_wr_en) begin
                chk("bp_dout", 32'(dout), 32'(8'(exp_out)));
                exp_out++;
                n_out++;
            end
            if (out_full) begin
                chk("bp_stall", 32'(in_rd_en), 32'(4'b0000));
                chk("bp_hold", 32'(dout), 32'(8'(exp_out)));
            end
            if (i == 10) begin
                chk("bp_rel_wr", 32'(out_wr_en), 32'(1'b1));
                chk("bp_rel_rd", 32'(in_rd_en), 32'(4'b0001));
            end
            popped = in_rd_en[0];
            tick();
            if (popped) next_in++;
        end
        chk("bp_count", 32'(n_out), 32'(20));
        out_full = 1'b0;

        // reset while a sample is held
        ch_mask = 4'b1111;
        sat_en  = 1'b1;
        set_din(100, 100, 50, 0);
        tick();
        #1;
        chk("pre_rst_wr", 32'(out_wr_en), 32'(1'b1));
        chk("pre_rst_sat", 32'(sat_flag), 32'(1'b1));
        reset = 1'b1;
        #1;
        chk("mid_rst_wr", 32'(out_wr_en), 32'(1'b0));
        chk("mid_rst_rd", 32'(in_rd_en), 32'(4'b0000));
        chk("mid_rst_frame", 32'(frame_done), 32'(1'b0));
        chk("mid_rst_sat", 32'(sat_flag), 32'(1'b0));
        chk("mid_rst_dout", 32'(dout), 32'(8'd0));
        tick();
        reset = 1'b0;
        set_din(1, 1, 1, 1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            #1;
            chk("rst_frame_wr", 32'(out_wr_en), 32'(1'b1));
            chk("rst_frame_pulse", 32'(frame_done), 32'(j == 4));
        end

        // SHIFT=2 instance: scaling and frame pulses
        s_mask  = 4'b1111;
        s_empty = 4'b0000;
        s_din   = {8'd7, 8'd7, 8'd7, 8'd7};
        #1;
        chk("s2_rd", 32'(s_rd_en), 32'(4'b1111));
        for (int w = 1; w <= 12; w++) begin
            tick();
            #1;
            chk("s2_wr", 32'(s_wr_en), 32'(1'b1));
            chk("s2_frame", 32'(s_frame_done), 32'((w % 4) == 0));
            if (w == 1) begin
                chk("s2_pos", 32'(s_dout), 32'(8'd7));
                s_din = 32'hFFFF_FFFF;
            end else if (w == 2) begin
                chk("s2_neg", 32'(s_dout), 32'(8'hFF));
                s_din = {8'hFE, 8'hFF, 8'hFF, 8'hFF};
            end else if (w == 3) begin
                chk("s2_floor", 32'(s_dout), 32'(8'hFE));
            end
        end
        chk("s2_sat", 32'(s_sat_flag), 32'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
